// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl                                              |
// | Brief    : Pipeline hazard controller driving IF/ID and ID/EX stall and  |
// |            flush for load-use, mul/div occupancy, redirects, exceptions. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_nop,
    input  logic       ex_mem_r,
    input  logic [4:0] ex_rt_addr,
    input  logic [3:0] ex_div_mul,
    input  logic       ex_branch_taken,
    input  logic       ex_jmp,
    input  logic       ex_jr,
    input  logic       ex_syscall,
    input  logic       ex_eret,
    input  logic       mem_wait,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_stall,
    output logic       idex_flush,
    output logic       md_start,
    output logic       md_done,
    output logic       exc_redirect
);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_MD  = 2'd1,
        ST_EXC = 2'd2
    } state_t;

    // The start cycle and the release cycle each account for one EX cycle,
    // so the counter only covers the LAT-2 cycles in between.
    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_ex_valid;
    logic w_md_req;
    logic w_md_is_div;
    logic w_exc_req;
    logic w_redirect_req;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_cnt_zero;

    // Every EX-sourced request is qualified by the slot not being a bubble.
    assign w_ex_valid     = ~ex_nop;
    assign w_md_req       = w_ex_valid & (ex_div_mul != 4'b0000);
    assign w_md_is_div    = ex_div_mul[3] | ex_div_mul[2];
    assign w_exc_req      = w_ex_valid & (ex_syscall | ex_eret);
    assign w_redirect_req = w_ex_valid & (ex_branch_taken | ex_jmp | ex_jr);
    assign w_rs_hit       = id_uses_rs & (id_rs_addr == ex_rt_addr);
    assign w_rt_hit       = id_uses_rt & (id_rt_addr == ex_rt_addr);
    assign w_load_use     = w_ex_valid & ex_mem_r & (ex_rt_addr != 5'd0)
                          & (w_rs_hit | w_rt_hit);
    assign w_cnt_zero     = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        md_start     = 1'b0;
        md_done      = 1'b0;
        exc_redirect = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (mem_wait) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_stall = 1'b1;
                end else if (w_md_req) begin
                    md_start    = 1'b1;
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    w_cnt_nxt   = w_md_is_div ? C_DIV_LOAD : C_MUL_LOAD;
                    w_state_nxt = ST_MD;
                end else if (w_exc_req) begin
                    exc_redirect = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    w_state_nxt  = ST_EXC;
                end else if (w_redirect_req) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end

            ST_MD: begin
                // Counting continues under mem_wait; only the release waits.
                if (!w_cnt_zero) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_stall = 1'b1;
                    w_cnt_nxt  = r_cnt - C_CNT_ONE;
                end else if (mem_wait) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_stall = 1'b1;
                end else begin
                    md_done     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_EXC: begin
                if (mem_wait) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_stall = 1'b1;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs follow reset immediately, independent of the clock.
        if (reset) begin
            pc_stall     = 1'b0;
            ifid_stall   = 1'b0;
            ifid_flush   = 1'b1;
            idex_stall   = 1'b0;
            idex_flush   = 1'b1;
            md_start     = 1'b0;
            md_done      = 1'b0;
            exc_redirect = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_hazard_ctrl                                           |
// | Brief    : Scoreboard bench for pipe_hazard_ctrl against a cycle model.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 33;
    localparam int CNT_W      = 6;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       nop;
        logic       mr;
        logic [4:0] ert;
        logic [3:0] dm;
        logic       br;
        logic       j;
        logic       jr;
        logic       sc;
        logic       er;
        logic       mw;
    } stim_t;

    typedef struct {
        logic [7:0] v;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs_addr = '0;
    logic [4:0] id_rt_addr = '0;
    logic       id_uses_rs = 1'b0;
    logic       id_uses_rt = 1'b0;
    logic       ex_nop = 1'b1;
    logic       ex_mem_r = 1'b0;
    logic [4:0] ex_rt_addr = '0;
    logic [3:0] ex_div_mul = '0;
    logic       ex_branch_taken = 1'b0;
    logic       ex_jmp = 1'b0;
    logic       ex_jr = 1'b0;
    logic       ex_syscall = 1'b0;
    logic       ex_eret = 1'b0;
    logic       mem_wait = 1'b0;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall;
    logic       idex_flush, md_start, md_done, exc_redirect;

    pipe_hazard_ctrl #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_nop          (ex_nop),
        .ex_mem_r        (ex_mem_r),
        .ex_rt_addr      (ex_rt_addr),
        .ex_div_mul      (ex_div_mul),
        .ex_branch_taken (ex_branch_taken),
        .ex_jmp          (ex_jmp),
        .ex_jr           (ex_jr),
        .ex_syscall      (ex_syscall),
        .ex_eret         (ex_eret),
        .mem_wait        (mem_wait),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_stall      (idex_stall),
        .idex_flush      (idex_flush),
        .md_start        (md_start),
        .md_done         (md_done),
        .exc_redirect    (exc_redirect)
    );

    always #5 clk = ~clk;

    // Output vector bit order: {pc_stall, ifid_stall, ifid_flush, idex_stall,
    //                           idex_flush, md_start, md_done, exc_redirect}
    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_RESET  = 8'b0010_1000;
    localparam logic [7:0] O_FREEZE = 8'b1101_0000;
    localparam logic [7:0] O_START  = 8'b1101_0100;
    localparam logic [7:0] O_DONE   = 8'b0000_0010;
    localparam logic [7:0] O_EXC    = 8'b0010_1001;
    localparam logic [7:0] O_FLUSH  = 8'b0010_1000;
    localparam logic [7:0] O_BUBBLE = 8'b1100_1000;

    // Reference model: mul/div tracked as elapsed EX cycles against latency.
    bit   m_busy;
    int   m_elapsed;
    int   m_lat;
    bit   m_exc;
    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    function automatic bit load_use(stim_t s);
        return !s.nop && s.mr && (s.ert != 0) &&
               ((s.urs && s.rs == s.ert) || (s.urt && s.rt == s.ert));
    endfunction

    function automatic logic [7:0] model_out(stim_t s);
        if (s.rst) return O_RESET;
        if (m_busy) return (m_elapsed >= m_lat - 1 && !s.mw) ? O_DONE : O_FREEZE;
        if (m_exc) return s.mw ? O_FREEZE : O_FLUSH;
        if (s.mw) return O_FREEZE;
        if (!s.nop && s.dm != 0) return O_START;
        if (!s.nop && (s.sc || s.er)) return O_EXC;
        if (!s.nop && (s.br || s.j || s.jr)) return O_FLUSH;
        if (load_use(s)) return O_BUBBLE;
        return O_NONE;
    endfunction

    task automatic model_step(stim_t s);
        if (s.rst) begin
            m_busy = 0;
            m_exc  = 0;
        end else if (m_busy) begin
            if (m_elapsed >= m_lat - 1 && !s.mw) m_busy = 0;
            else m_elapsed++;
        end else if (m_exc) begin
            if (!s.mw) m_exc = 0;
        end else if (!s.mw && !s.nop) begin
            if (s.dm != 0) begin
                m_busy    = 1;
                m_elapsed = 1;
                m_lat     = (s.dm[3] || s.dm[2]) ? DIV_CYCLES : MUL_CYCLES;
            end else if (s.sc || s.er) begin
                m_exc = 1;
            end
        end
    endtask

    // Called at posedge+1: drive, predict, then advance the model at the edge.
    task automatic apply(stim_t s);
        exp_t e;
        reset           = s.rst;
        id_rs_addr      = s.rs;
        id_rt_addr      = s.rt;
        id_uses_rs      = s.urs;
        id_uses_rt      = s.urt;
        ex_nop          = s.nop;
        ex_mem_r        = s.mr;
        ex_rt_addr      = s.ert;
        ex_div_mul      = s.dm;
        ex_branch_taken = s.br;
        ex_jmp          = s.j;
        ex_jr           = s.jr;
        ex_syscall      = s.sc;
        ex_eret         = s.er;
        mem_wait        = s.mw;
        e.v   = model_out(s);
        e.cyc = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        model_step(s);
        cyc++;
        #1;
    endtask

    function automatic stim_t idle_s();
        stim_t s = '0;
        s.nop = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_s();
        stim_t s;
        s.rst = ($urandom_range(0, 199) == 0);
        s.rs  = 5'($urandom_range(0, 3));
        s.rt  = 5'($urandom_range(0, 3));
        s.urs = 1'($urandom);
        s.urt = 1'($urandom);
        s.nop = ($urandom_range(0, 9) < 3);
        s.mr  = 1'($urandom);
        s.ert = 5'($urandom_range(0, 3));
        s.dm  = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        s.br  = ($urandom_range(0, 7) == 0);
        s.j   = ($urandom_range(0, 15) == 0);
        s.jr  = ($urandom_range(0, 15) == 0);
        s.sc  = ($urandom_range(0, 19) == 0);
        s.er  = ($urandom_range(0, 19) == 0);
        s.mw  = ($urandom_range(0, 4) == 0);
        return s;
    endfunction

    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {pc_stall, ifid_stall, ifid_flush, idex_stall,
                       idex_flush, md_start, md_done, exc_redirect};
                n_total++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL ctrl_outputs cyc=%0d got=%b expected=%b", e.cyc, got, e.v);
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        @(posedge clk);
        #1;
        s = idle_s(); s.rst = 1'b1;
        apply(s);
        apply(s);
        apply(idle_s());

        // Load-use on rs, then release.
        s = idle_s(); s.nop = 0; s.mr = 1; s.ert = 5'd5; s.rs = 5'd5; s.rt = 5'd1; s.urs = 1;
        apply(s);
        apply(idle_s());
        // Load to $0 and a load in a bubble slot must not stall.
        s = idle_s(); s.nop = 0; s.mr = 1; s.ert = 5'd0; s.rs = 5'd0; s.urs = 1; s.urt = 1;
        apply(s);
        s = idle_s(); s.mr = 1; s.ert = 5'd5; s.rs = 5'd5; s.urs = 1;
        apply(s);
        // Load-use through rt only.
        s = idle_s(); s.nop = 0; s.mr = 1; s.ert = 5'd7; s.rt = 5'd7; s.urt = 1;
        apply(s);

        // Full divide.
        s = idle_s(); s.nop = 0; s.dm = 4'b0100;
        apply(s);
        for (int i = 0; i < DIV_CYCLES + 2; i++) apply(idle_s());

        // Multiply with mem_wait covering the release point.
        s = idle_s(); s.nop = 0; s.dm = 4'b0001;
        apply(s);
        apply(idle_s());
        for (int i = 2; i <= 6; i++) begin
            s = idle_s(); s.mw = 1;
            apply(s);
        end
        for (int i = 0; i < 3; i++) apply(idle_s());

        // Non-one-hot code resolves as divide.
        s = idle_s(); s.nop = 0; s.dm = 4'b0101;
        apply(s);
        for (int i = 0; i < DIV_CYCLES + 1; i++) apply(idle_s());

        // Syscall together with jr, then EXC held by mem_wait.
        s = idle_s(); s.nop = 0; s.sc = 1; s.jr = 1;
        apply(s);
        apply(idle_s());
        apply(idle_s());
        s = idle_s(); s.nop = 0; s.er = 1;
        apply(s);
        s = idle_s(); s.mw = 1;
        apply(s);
        apply(idle_s());
        apply(idle_s());

        // Reset in the middle of a divide: no md_done afterwards.
        s = idle_s(); s.nop = 0; s.dm = 4'b1000;
        apply(s);
        for (int i = 0; i < 22; i++) apply(idle_s());
        s = idle_s(); s.rst = 1;
        apply(s);
        for (int i = 0; i < DIV_CYCLES + 2; i++) apply(idle_s());

        for (int i = 0; i < 3000; i++) apply(rand_s());
        apply(idle_s());

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
